// File: rtl/key_pulse_if.sv
// Key-pulse bundle between the button front end (master) and the game control FSM (slave).
// Carries the raw buttons, the enable, the one-cycle direction pulses and the debounced key levels.
interface key_pulse_if;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       en;
  logic       U;
  logic       D;
  logic       L;
  logic       R;
  logic [3:0] held;

  modport master (
    input  btn_u, btn_d, btn_l, btn_r, en,
    output U, D, L, R, held
  );

  modport slave (
    output btn_u, btn_d, btn_l, btn_r, en,
    input  U, D, L, R, held
  );
endinterface

// File: rtl/key_pulse_gen.sv
// Synchronises and debounces four push-buttons and turns presses (plus optional hold-to-repeat)
// into one-cycle U/D/L/R pulses, one at a time, spaced at least GAP_CYCLES apart.
module key_pulse_gen #(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic clr,
  key_pulse_if.master kif
);

  localparam int unsigned DW   = $clog2(DB_CYCLES);
  localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  // Key vectors are ordered {u,d,l,r}; bit 3 has the highest priority.
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    s;
  logic [3:0]    stable;
  logic [3:0]    stable_q;
  logic [3:0]    rise;
  logic [DW-1:0] db_cnt [4];

  logic [3:0]    pending, pending_n;
  logic [3:0]    grant;
  logic [3:0]    pulse;
  logic [GW-1:0] gap_cnt, gap_n;

  rpt_state_t    state, state_n;
  logic [1:0]    key, key_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [3:0]    rpt_set;

  function automatic logic [3:0] first_one(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else if (v[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  function automatic logic [1:0] key_idx(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign raw = {kif.btn_u, kif.btn_d, kif.btn_l, kif.btn_r};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // NOTE: the debounce counters are few and small, so they are reset like ordinary flops.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 4; i++) begin
        if (s[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          stable[i] <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    key_n   = key;
    rcnt_n  = rcnt;
    rpt_set = '0;
    if (!REPEAT_EN || !kif.en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise != '0) begin
            state_n = DELAY;
            key_n   = key_idx(rise);
            rcnt_n  = RW'(REPEAT_DELAY - 1);
          end
        end
        DELAY, RPT: begin
          if (rise != '0) begin
            state_n = DELAY;
            key_n   = key_idx(rise);
            rcnt_n  = RW'(REPEAT_DELAY - 1);
          end else if (!stable[key]) begin
            state_n = IDLE;
          end else if (rcnt == '0) begin
            rpt_set[key] = 1'b1;
            rcnt_n       = RW'(REPEAT_PERIOD - 1);
            state_n      = RPT;
          end else begin
            rcnt_n = rcnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Pending bits are flags, not counters: a repeat or press on an already pending key merges.
  always_comb begin
    grant     = (gap_cnt == '0 && kif.en) ? first_one(pending) : 4'b0000;
    pending_n = kif.en ? ((pending & ~grant) | rise | rpt_set) : 4'b0000;
    if (grant != '0)        gap_n = GW'(GAP_CYCLES - 1);
    else if (gap_cnt != '0) gap_n = gap_cnt - 1'b1;
    else                    gap_n = '0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      key     <= '0;
      rcnt    <= '0;
      pending <= '0;
      gap_cnt <= '0;
      pulse   <= '0;
    end else begin
      state   <= state_n;
      key     <= key_n;
      rcnt    <= rcnt_n;
      pending <= pending_n;
      gap_cnt <= gap_n;
      pulse   <= grant;
    end
  end

  assign kif.U    = pulse[3];
  assign kif.D    = pulse[2];
  assign kif.L    = pulse[1];
  assign kif.R    = pulse[0];
  assign kif.held = stable;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with an 8-cycle debounce, gap 4 and repeat delay/period 20/10.
// A negedge monitor logs every pulse (cycle, key) and guards one-hot and minimum-gap behaviour.
module tb_key_pulse_gen;
  localparam int DB  = 8;
  localparam int GAP = 4;
  localparam int RD  = 20;
  localparam int RP  = 10;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  key_pulse_if kif ();

  key_pulse_gen #(
    .DB_CYCLES    (DB),
    .GAP_CYCLES   (GAP),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .clr(clr),
    .kif(kif)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_pulse = -100;
  int p_cyc[$];
  int p_key[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Key codes in the log: 0=U 1=D 2=L 3=R.
  always @(negedge clk) begin : monitor
    logic [3:0] p;
    p = {kif.U, kif.D, kif.L, kif.R};
    if (!clr) begin
      checks++;
      assert ($onehot0(p)) else begin
        errors++;
        $error("FAIL onehot: observed %b expected at most one bit at cycle %0d", p, cyc);
      end
      if (p != 4'b0000) begin
        checks++;
        assert (cyc - last_pulse >= GAP) else begin
          errors++;
          $error("FAIL gap: observed %0d cycles expected >= %0d at cycle %0d", cyc - last_pulse, GAP, cyc);
        end
        last_pulse = cyc;
        p_cyc.push_back(cyc);
        case (p)
          4'b1000: p_key.push_back(0);
          4'b0100: p_key.push_back(1);
          4'b0010: p_key.push_back(2);
          default: p_key.push_back(3);
        endcase
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    p_cyc.delete();
    p_key.delete();
  endtask

  task automatic check_pulse(input string tag, input int i, input int exp_key, input int exp_cyc);
    int k;
    int c;
    k = (i < p_key.size()) ? p_key[i] : -1;
    c = (i < p_cyc.size()) ? p_cyc[i] : -1;
    check({tag, "_key"}, k, exp_key);
    check({tag, "_cycle"}, c, exp_cyc);
  endtask

  int t;
  int rpt_at [5] = '{12, 32, 42, 52, 62};

  initial begin
    clr       = 1'b1;
    kif.btn_u = 1'b0;
    kif.btn_d = 1'b0;
    kif.btn_l = 1'b0;
    kif.btn_r = 1'b0;
    kif.en    = 1'b1;

    // Reset state
    wait_n(3);
    check("reset_pulses", int'({kif.U, kif.D, kif.L, kif.R}), 0);
    check("reset_held", int'(kif.held), 0);
    clr = 1'b0;
    wait_n(3);

    // Single L press: pulse after edge 12, held[1] set
    clear_log();
    t = cyc;
    kif.btn_l = 1'b1;
    wait_n(11);
    check("l_early", int'(kif.L), 0);
    check("l_held", int'(kif.held), 4'b0010);
    wait_n(1);
    check("l_pulse", int'(kif.L), 1);
    wait_n(1);
    check("l_one_cycle", int'(kif.L), 0);
    wait_n(1);
    kif.btn_l = 1'b0;
    wait_n(30);
    check("l_count", p_cyc.size(), 1);
    check_pulse("l", 0, 2, t + 12);
    check("l_released", int'(kif.held), 0);

    // Bouncing R: 3 high / 2 low x5, then steady high
    clear_log();
    for (int i = 0; i < 5; i++) begin
      kif.btn_r = 1'b1;
      wait_n(3);
      kif.btn_r = 1'b0;
      wait_n(2);
    end
    check("r_bounce_held", int'(kif.held), 0);
    t = cyc;
    kif.btn_r = 1'b1;
    wait_n(14);
    kif.btn_r = 1'b0;
    wait_n(30);
    check("r_count", p_cyc.size(), 1);
    check_pulse("r", 0, 3, t + 12);

    // U and R together: U first, R exactly GAP later
    clear_log();
    t = cyc;
    kif.btn_u = 1'b1;
    kif.btn_r = 1'b1;
    wait_n(11);
    check("ur_held", int'(kif.held), 4'b1001);
    wait_n(7);
    kif.btn_u = 1'b0;
    kif.btn_r = 1'b0;
    wait_n(30);
    check("ur_count", p_cyc.size(), 2);
    check_pulse("ur_u", 0, 0, t + 12);
    check_pulse("ur_r", 1, 3, t + 16);

    // D held: press pulse, then repeats at +20 and every 10 after; stops on release
    clear_log();
    t = cyc;
    kif.btn_d = 1'b1;
    wait_n(55);
    kif.btn_d = 1'b0;
    wait_n(40);
    check("d_count", p_cyc.size(), 5);
    for (int i = 0; i < 5; i++) check_pulse($sformatf("d%0d", i), i, 1, t + rpt_at[i]);

    // en low during L press, raised while held: no pulse until a fresh press
    clear_log();
    kif.en = 1'b0;
    wait_n(1);
    kif.btn_l = 1'b1;
    wait_n(20);
    kif.en = 1'b1;
    wait_n(30);
    check("en_held", int'(kif.held), 4'b0010);
    check("en_no_pulse", p_cyc.size(), 0);
    kif.btn_l = 1'b0;
    wait_n(20);
    t = cyc;
    kif.btn_l = 1'b1;
    wait_n(14);
    kif.btn_l = 1'b0;
    wait_n(30);
    check("en_repress_count", p_cyc.size(), 1);
    check_pulse("en_repress", 0, 2, t + 12);

    // clr during the repeat delay: outputs clear, no repeat afterwards
    clear_log();
    t = cyc;
    kif.btn_d = 1'b1;
    wait_n(20);
    check("clr_pre_held", int'(kif.held), 4'b0100);
    clr = 1'b1;
    kif.btn_d = 1'b0;
    wait_n(1);
    check("clr_pulses", int'({kif.U, kif.D, kif.L, kif.R}), 0);
    check("clr_held", int'(kif.held), 0);
    wait_n(1);
    clr = 1'b0;
    wait_n(40);
    check("clr_count", p_cyc.size(), 1);
    check_pulse("clr_press", 0, 1, t + 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
